aq_f_spsram_ctrl: RTL and testbench

//  Requester-side controller for the aq_f_spsram_* single-port SRAM wrappers (default 64x88).

---
 rtl/aq_f_spsram_ctrl.sv | 142 ++++++++++++++
 tb/tb_aq_f_spsram_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_f_spsram_ctrl.sv
// Requester-side controller for a single-port SRAM: valid/ready request channel in,
// SRAM strobes out, registered read-response slot, and whole-array zero-fill on reset/clear.
module aq_f_spsram_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 88
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  clr_req,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int                    DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  r_init_done;
    logic                  w_init_done_nxt;
    logic                  r_rd_pend;
    logic                  r_rsp_vld;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_idle;
    logic                  w_clr_go;
    logic                  w_req_rdy;
    logic                  w_fire;

    assign w_idle    = (r_state == ST_IDLE);
    // A clear only proceeds once no read is in flight and the response slot is empty.
    assign w_clr_go  = w_idle & clr_req & ~r_rd_pend & ~r_rsp_vld;
    assign w_req_rdy = w_idle & ~clr_req & ~r_rd_pend & (~r_rsp_vld | rsp_rdy);
    assign w_fire    = req_vld & w_req_rdy;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_cnt_nxt       = '0;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_clr_go) begin
                    w_state_nxt     = ST_INIT;
                    w_cnt_nxt       = '0;
                    w_init_done_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // SRAM strobes: zero-fill while initialising, pass the accepted request otherwise.
    always_comb begin
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_d    = '0;
        if (!cpurst) begin
            if (r_state == ST_INIT) begin
                sram_a    = r_cnt;
                sram_cen  = 1'b0;
                sram_gwen = 1'b1;
                sram_wen  = '1;
            end else if (w_fire) begin
                sram_a    = req_addr;
                sram_cen  = 1'b0;
                sram_gwen = req_wr;
                sram_wen  = req_wr ? req_wmask : '0;
                sram_d    = req_wdata;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_rd_pend   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rd_pend <= w_fire & ~req_wr;
            // The accept condition guarantees the slot is empty when sram_q lands.
            if (r_rd_pend) begin
                r_rsp_vld   <= 1'b1;
                r_rsp_rdata <= sram_q;
            end else if (r_rsp_vld & rsp_rdy) begin
                r_rsp_vld <= 1'b0;
            end
        end
    end

    assign init_done = r_init_done;
    assign req_rdy   = w_req_rdy;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_aq_f_spsram_ctrl.sv
// Self-checking bench for aq_f_spsram_ctrl: behavioural SRAM plus an expected-contents
// array updated from the masked-write rule, with randomized data, masks and addresses.
module tb_aq_f_spsram_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 88;
    localparam int DEPTH = 64;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst         = 1'b1;
    logic          clr_req        = 1'b0;
    logic          init_done;
    logic          req_vld        = 1'b0;
    logic          req_rdy;
    logic          req_wr         = 1'b0;
    logic [AW-1:0] req_addr       = '0;
    logic [DW-1:0] req_wdata      = '0;
    logic [DW-1:0] req_wmask      = '0;
    logic          rsp_vld;
    logic          rsp_rdy        = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q         = '0;

    int vecs = 0;
    int errs = 0;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];

    aq_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst(cpurst), .clr_req(clr_req),
        .init_done(init_done), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Single-port SRAM: per-bit write enable, Q valid the cycle after a read strobe.
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
            else           sram_q <= sram_mem[sram_a];
        end
    end

    function automatic logic [DW-1:0] rnd88();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        #1;
        while (!req_rdy && n < 50) begin
            tick();
            #1;
            n++;
        end
        if (!req_rdy) begin
            errs++;
            $display("FAIL req_rdy_timeout: req_rdy=%0b required 1", req_rdy);
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!init_done && n < 300) begin
            tick();
            n++;
        end
        vecs++;
        if (init_done !== 1'b1) begin
            errs++;
            $display("FAIL init_timeout: init_done=%0b required 1", init_done);
        end
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        wait_rdy();
        tick();
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        req_vld = 1'b0; req_wr = 1'b0;
    endtask

    task automatic do_rd(input logic [AW-1:0] a, output logic [DW-1:0] data, output int lat);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = a; rsp_rdy = 1'b1;
        wait_rdy();
        tick();
        req_vld = 1'b0;
        lat = 1;
        while (!rsp_vld && lat < 10) begin
            tick();
            lat++;
        end
        data = rsp_rdata;
        tick();
    endtask

    task automatic test_reset();
        cpurst = 1'b1;
        tick(); tick();
        vecs++;
        if ({init_done, req_rdy, sram_cen, sram_gwen, rsp_vld} !== 5'b00100) begin
            errs++;
            $display("FAIL reset_flags: {done,rdy,cen,gwen,vld}=%b required 00100",
                     {init_done, req_rdy, sram_cen, sram_gwen, rsp_vld});
        end
        vecs++;
        if (rsp_rdata !== '0) begin
            errs++;
            $display("FAIL reset_rdata: %h required 0", rsp_rdata);
        end
        cpurst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            vecs++;
            if ({sram_cen, sram_gwen, sram_a, sram_wen == '1, sram_d == '0, init_done} !==
                {1'b0, 1'b1, AW'(i), 1'b1, 1'b1, 1'b0}) begin
                errs++;
                $display("FAIL init_write_%0d: cen=%b gwen=%b a=%0d done=%b required cen=0 gwen=1 a=%0d done=0",
                         i, sram_cen, sram_gwen, sram_a, init_done, i);
            end
            tick();
        end
        vecs++;
        if ({init_done, sram_cen} !== 2'b11) begin
            errs++;
            $display("FAIL init_done_cycle65: done=%b cen=%b required done=1 cen=1", init_done, sram_cen);
        end
        clear_ref();
    endtask

    task automatic test_read_all(input string tag);
        logic [DW-1:0] d;
        int            lat;
        for (int i = 0; i < DEPTH; i++) begin
            do_rd(AW'(i), d, lat);
            vecs++;
            if (d !== ref_mem[i] || lat != 2) begin
                errs++;
                $display("FAIL %s_addr%0d: data=%h lat=%0d required data=%h lat=2", tag, i, d, lat, ref_mem[i]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        int            lat;
        do_wr(6'd5, {11{8'hA5}}, '1);
        do_rd(6'd5, d, lat);
        vecs++;
        if (d !== {11{8'hA5}} || lat != 2) begin
            errs++;
            $display("FAIL write_read_a5: data=%h lat=%0d required data=%h lat=2", d, lat, {11{8'hA5}});
        end
    endtask

    task automatic test_masked_write();
        logic [DW-1:0] d;
        logic [DW-1:0] w;
        int            lat;
        w = rnd88() | {DW{1'b1}} << 80;
        do_wr(6'd9, w, 88'hFF);
        do_rd(6'd9, d, lat);
        vecs++;
        if (d !== ref_mem[9] || d[DW-1:8] !== '0) begin
            errs++;
            $display("FAIL masked_write: data=%h required %h", d, ref_mem[9]);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int            lat;
        for (int k = 0; k < 60; k++) begin
            a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_wr(a, rnd88(), ($urandom_range(0, 2) == 0) ? '1 : rnd88());
            end else begin
                do_rd(a, d, lat);
                vecs++;
                if (d !== ref_mem[a] || lat != 2) begin
                    errs++;
                    $display("FAIL random_rd_%0d: addr=%0d data=%h lat=%0d required data=%h lat=2",
                             k, a, d, lat, ref_mem[a]);
                end
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] held;
        logic [AW-1:0] a0, a1;
        int            n;
        a0 = 6'd20; a1 = 6'd21;
        do_wr(a0, rnd88(), '1);
        do_wr(a1, rnd88(), '1);
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = a0;
        wait_rdy();
        tick();
        req_addr = a1;
        #1;
        vecs++;
        if (req_rdy !== 1'b0) begin
            errs++;
            $display("FAIL b2b_rdpend_rdy: req_rdy=%b required 0", req_rdy);
        end
        tick();
        held = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            #1;
            vecs++;
            if ({req_rdy, rsp_vld} !== 2'b01 || rsp_rdata !== held) begin
                errs++;
                $display("FAIL b2b_hold_%0d: rdy=%b vld=%b data=%h required rdy=0 vld=1 data=%h",
                         i, req_rdy, rsp_vld, rsp_rdata, held);
            end
            tick();
        end
        rsp_rdy = 1'b1;
        #1;
        vecs++;
        if (req_rdy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_release_rdy: req_rdy=%b required 1", req_rdy);
        end
        tick();
        req_vld = 1'b0;
        vecs++;
        if (held !== ref_mem[a0]) begin
            errs++;
            $display("FAIL b2b_first_data: %h required %h", held, ref_mem[a0]);
        end
        n = 1;
        while (!rsp_vld && n < 10) begin
            tick();
            n++;
        end
        vecs++;
        if (rsp_rdata !== ref_mem[a1] || n != 2) begin
            errs++;
            $display("FAIL b2b_second: data=%h lat=%0d required data=%h lat=2", rsp_rdata, n, ref_mem[a1]);
        end
        tick();
    endtask

    task automatic test_clear();
        logic [DW-1:0] held;
        do_wr(6'd3, rnd88() | 88'h1, '1);
        do_wr(6'd40, rnd88() | 88'h1, '1);
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd3;
        wait_rdy();
        tick();
        req_vld = 1'b0;
        tick();
        clr_req = 1'b1;
        held = rsp_rdata;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if ({sram_cen, init_done, rsp_vld} !== 3'b111) begin
                errs++;
                $display("FAIL clr_blocked_%0d: cen=%b done=%b vld=%b required 111", i, sram_cen, init_done, rsp_vld);
            end
            tick();
        end
        vecs++;
        if (held !== ref_mem[3]) begin
            errs++;
            $display("FAIL clr_held_data: %h required %h", held, ref_mem[3]);
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 6'd40; req_wdata = '1; req_wmask = '1;
        #1;
        vecs++;
        if ({req_rdy, sram_cen} !== 2'b01) begin
            errs++;
            $display("FAIL clr_wins: rdy=%b cen=%b required rdy=0 cen=1", req_rdy, sram_cen);
        end
        tick();
        req_vld = 1'b0; req_wr = 1'b0;
        clr_req = 1'b0;
        #1;
        vecs++;
        if ({sram_cen, sram_gwen, sram_a, init_done} !== {1'b0, 1'b1, 6'd0, 1'b0}) begin
            errs++;
            $display("FAIL clr_init_start: cen=%b gwen=%b a=%0d done=%b required 0 1 0 0",
                     sram_cen, sram_gwen, sram_a, init_done);
        end
        wait_init();
        clear_ref();
        test_read_all("clr_read");
    endtask

    task automatic test_reset_midop();
        do_wr(6'd7, rnd88() | 88'h1, '1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        #1;
        vecs++;
        if ({sram_cen, sram_a} !== {1'b0, 6'd30}) begin
            errs++;
            $display("FAIL rst_init_at30: cen=%b a=%0d required cen=0 a=30", sram_cen, sram_a);
        end
        cpurst = 1'b1;
        #1;
        vecs++;
        if ({sram_cen, init_done, rsp_vld} !== 3'b100) begin
            errs++;
            $display("FAIL rst_during_init: cen=%b done=%b vld=%b required 100", sram_cen, init_done, rsp_vld);
        end
        tick();
        cpurst = 1'b0;
        #1;
        vecs++;
        if ({sram_cen, sram_a} !== {1'b0, 6'd0}) begin
            errs++;
            $display("FAIL rst_init_restart: cen=%b a=%0d required cen=0 a=0", sram_cen, sram_a);
        end
        wait_init();
        clear_ref();
        do_wr(6'd11, rnd88() | 88'h1, '1);
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd11;
        wait_rdy();
        tick();
        req_vld = 1'b0;
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if ({rsp_vld, sram_cen, sram_a} !== {1'b0, 1'b0, AW'(i)}) begin
                errs++;
                $display("FAIL rst_rdpend_%0d: vld=%b cen=%b a=%0d required vld=0 cen=0 a=%0d",
                         i, rsp_vld, sram_cen, sram_a, i);
            end
            tick();
        end
        wait_init();
        clear_ref();
        test_read_all("rst_read");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = rnd88();
        clear_ref();
        test_reset();
        test_read_all("init_read");
        test_write_read();
        test_masked_write();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
